// File: rtl/mutex_invariant_monitor.sv
// mutex_invariant_monitor: checks mutual-exclusion invariants and per-process transitions on sampled state.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   valid, n, x         sample strobe, per-process states (proc i at n[2i+1:2i]; I/T/C/E), shared free flag
//   clr                 synchronous clear of errors/counters, re-arms the first-sample check
//   err, err_code       sticky violation flag and code (1 MUTEX, 2 FLAG, 3 TRANS, 4 INIT)
//   err_pid             process tied to the recorded error
//   starve              per-process: waiting in T for STARVE_LIM samples or more
//   crit_count          legal T->C entries observed (saturating)
//   samp_count          violation-free valid samples checked (saturating)
module mutex_invariant_monitor #(
    parameter int NPROC = 2,
    parameter int CNT_W = 16,
    parameter int STARVE_LIM = 64,
    parameter int SINGLE_STEP = 1,
    localparam int PID_W = (NPROC > 1) ? $clog2(NPROC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [2*NPROC-1:0]   n,
    input  logic                 x,
    input  logic                 clr,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [PID_W-1:0]     err_pid,
    output logic [NPROC-1:0]     starve,
    output logic [CNT_W-1:0]     crit_count,
    output logic [CNT_W-1:0]     samp_count
);
    localparam int WAIT_W = $clog2(STARVE_LIM + 1);
    localparam logic [1:0] ST_ARM = 2'd0, ST_CHECK = 2'd1, ST_HALT = 2'd2;
    localparam logic [1:0] P_I = 2'b00, P_T = 2'b01, P_C = 2'b10;

    logic [1:0]         state;
    logic [2*NPROC-1:0] prev_n;
    logic               prev_x;
    logic [WAIT_W-1:0]  wait_cnt [NPROC];
    logic               any_cs, multi_cs, seen1, seen2, viol;
    logic [NPROC-1:0]   offend, entry;
    logic [PID_W-1:0]   trans_pid, init_pid;
    logic [2:0]         code_nxt;
    logic [CNT_W-1:0]   crit_nxt;
    logic [1:0]         p, c;

    always_comb begin
        any_cs   = 1'b0;
        multi_cs = 1'b0;
        seen1    = 1'b0;
        seen2    = 1'b0;
        offend   = '0;
        entry    = '0;
        crit_nxt = crit_count;
        p        = P_I;
        c        = P_I;
        trans_pid = '0;
        init_pid  = '0;
        for (int i = 0; i < NPROC; i++) begin
            p = prev_n[2*i +: 2];
            c = n[2*i +: 2];
            // C and E both have the high bit set
            multi_cs = multi_cs | (any_cs & c[1]);
            any_cs   = any_cs | c[1];
            // legal moves are hold or one step around I->T->C->E->I (2-bit wrap), T->C only when the flag was free
            offend[i] = !(c == p || (c == p + 2'd1 && !(p == P_T && !prev_x)));
            entry[i]  = p == P_T && c == P_C && prev_x;
            if (c != p) begin
                // the second changing process is the one blamed for a multi-step sample
                if (seen1 && !seen2 && SINGLE_STEP != 0) offend[i] = 1'b1;
                seen2 = seen1;
                seen1 = 1'b1;
            end
            crit_nxt = (entry[i] && crit_nxt != '1) ? crit_nxt + CNT_W'(1) : crit_nxt;
        end
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (offend[i]) trans_pid = PID_W'(i);
            if (n[2*i +: 2] != P_I) init_pid = PID_W'(i);
        end
        code_nxt = multi_cs ? 3'd1 : (x == any_cs) ? 3'd2 : (|offend) ? 3'd3 : 3'd0;
        viol     = code_nxt != 3'd0;
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < NPROC; i++) starve[i] = wait_cnt[i] == WAIT_W'(STARVE_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ARM;
            err        <= 1'b0;
            err_code   <= '0;
            err_pid    <= '0;
            crit_count <= '0;
            samp_count <= '0;
            prev_n     <= '0;
            prev_x     <= 1'b1;
            for (int i = 0; i < NPROC; i++) wait_cnt[i] <= '0;
        end else if (clr) begin
            state      <= ST_ARM;
            err        <= 1'b0;
            err_code   <= '0;
            err_pid    <= '0;
            crit_count <= '0;
            samp_count <= '0;
            prev_n     <= '0;
            prev_x     <= 1'b1;
            for (int i = 0; i < NPROC; i++) wait_cnt[i] <= '0;
        end else if (valid && state == ST_ARM) begin
            if (n == '0 && x) begin
                state      <= ST_CHECK;
                prev_n     <= n;
                prev_x     <= x;
                samp_count <= (samp_count != '1) ? samp_count + CNT_W'(1) : samp_count;
            end else begin
                state    <= ST_HALT;
                err      <= 1'b1;
                err_code <= 3'd4;
                err_pid  <= init_pid;
            end
        end else if (valid && state == ST_CHECK) begin
            if (viol) begin
                state    <= ST_HALT;
                err      <= 1'b1;
                err_code <= code_nxt;
                err_pid  <= (code_nxt == 3'd3) ? trans_pid : '0;
            end else begin
                prev_n     <= n;
                prev_x     <= x;
                samp_count <= (samp_count != '1) ? samp_count + CNT_W'(1) : samp_count;
                crit_count <= crit_nxt;
                for (int i = 0; i < NPROC; i++)
                    wait_cnt[i] <= (n[2*i +: 2] != P_T) ? '0 :
                                   (wait_cnt[i] == WAIT_W'(STARVE_LIM)) ? wait_cnt[i] : wait_cnt[i] + WAIT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mutex_invariant_monitor.sv
// tb_mutex_invariant_monitor: scoreboard bench for two monitor configurations driven by shared stimulus.
module tb_mutex_invariant_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, valid = 1'b0, x = 1'b1, clr = 1'b0;
    logic [3:0] n = '0;

    logic a_err, b_err, a_pid, b_pid;
    logic [2:0] a_code, b_code;
    logic [1:0] a_starve, b_starve;
    logic [15:0] a_crit, a_samp;
    logic [3:0]  b_crit, b_samp;

    mutex_invariant_monitor #(.NPROC(2), .CNT_W(16), .STARVE_LIM(4), .SINGLE_STEP(1)) dut_a (
        .clk(clk), .reset(reset), .valid(valid), .n(n), .x(x), .clr(clr),
        .err(a_err), .err_code(a_code), .err_pid(a_pid), .starve(a_starve),
        .crit_count(a_crit), .samp_count(a_samp));

    mutex_invariant_monitor #(.NPROC(2), .CNT_W(4), .STARVE_LIM(3), .SINGLE_STEP(0)) dut_b (
        .clk(clk), .reset(reset), .valid(valid), .n(n), .x(x), .clr(clr),
        .err(b_err), .err_code(b_code), .err_pid(b_pid), .starve(b_starve),
        .crit_count(b_crit), .samp_count(b_samp));

    typedef struct {int err; int code; int pid; int starve; int crit; int samp;} obs_t;
    obs_t qa[$], qb[$];
    int checks = 0, failures = 0;

    // reference model: mode 0 arm, 1 check, 2 halt; process states 0 I, 1 T, 2 C, 3 E
    int m_mode[2], m_px[2], m_err[2], m_code[2], m_pid[2], m_crit[2], m_samp[2];
    int m_prev[2][2], m_wait[2][2];
    int p_ss[2]  = '{1, 0};
    int p_lim[2] = '{4, 3};
    int p_max[2] = '{65535, 15};

    function automatic int sat(int v, int m);
        return v > m ? m : v;
    endfunction

    function automatic void model_reset(int k);
        m_mode[k] = 0; m_px[k] = 1; m_err[k] = 0; m_code[k] = 0; m_pid[k] = 0;
        m_crit[k] = 0; m_samp[k] = 0;
        for (int i = 0; i < 2; i++) begin m_prev[k][i] = 0; m_wait[k][i] = 0; end
    endfunction

    function automatic void model_step(int k, bit v, logic [3:0] nv, bit xv, bit cl);
        int st[2];
        int ncs, nchg, second, tpid, code;
        if (cl) begin model_reset(k); return; end
        if (!v || m_mode[k] == 2) return;
        for (int i = 0; i < 2; i++) st[i] = int'(nv[2*i +: 2]);
        if (m_mode[k] == 0) begin
            if (st[0] == 0 && st[1] == 0 && xv) begin
                m_mode[k] = 1; m_px[k] = 1; m_samp[k] = sat(m_samp[k] + 1, p_max[k]);
            end else begin
                m_mode[k] = 2; m_err[k] = 1; m_code[k] = 4;
                m_pid[k] = (st[0] != 0) ? 0 : (st[1] != 0) ? 1 : 0;
            end
            return;
        end
        ncs = 0; nchg = 0; second = -1; tpid = -1;
        for (int i = 0; i < 2; i++) begin
            if (st[i] >= 2) ncs++;
            if (st[i] != m_prev[k][i]) begin
                nchg++;
                if (nchg == 2) second = i;
                if (!(st[i] == (m_prev[k][i] + 1) % 4 && !(m_prev[k][i] == 1 && m_px[k] == 0)) && tpid < 0) tpid = i;
            end
        end
        if (p_ss[k] == 1 && second >= 0 && (tpid < 0 || second < tpid)) tpid = second;
        code = (ncs > 1) ? 1 : ((xv == 1) == (ncs > 0)) ? 2 : (tpid >= 0) ? 3 : 0;
        if (code != 0) begin
            m_mode[k] = 2; m_err[k] = 1; m_code[k] = code; m_pid[k] = (code == 3) ? tpid : 0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_prev[k][i] == 1 && st[i] == 2) m_crit[k] = sat(m_crit[k] + 1, p_max[k]);
            m_wait[k][i] = (st[i] == 1) ? sat(m_wait[k][i] + 1, p_lim[k]) : 0;
            m_prev[k][i] = st[i];
        end
        m_px[k] = xv;
        m_samp[k] = sat(m_samp[k] + 1, p_max[k]);
    endfunction

    function automatic obs_t exp_of(int k);
        obs_t o;
        o.err = m_err[k]; o.code = m_code[k]; o.pid = m_pid[k];
        o.starve = (m_wait[k][0] == p_lim[k] ? 1 : 0) + (m_wait[k][1] == p_lim[k] ? 2 : 0);
        o.crit = m_crit[k]; o.samp = m_samp[k];
        return o;
    endfunction

    task automatic compare(string name, obs_t a, obs_t e);
        checks++;
        if (a.err != e.err || a.code != e.code || a.pid != e.pid || a.starve != e.starve ||
            a.crit != e.crit || a.samp != e.samp) begin
            failures++;
            $display("FAIL %s t=%0t: got err=%0d code=%0d pid=%0d starve=%0d crit=%0d samp=%0d, expected err=%0d code=%0d pid=%0d starve=%0d crit=%0d samp=%0d",
                     name, $time, a.err, a.code, a.pid, a.starve, a.crit, a.samp,
                     e.err, e.code, e.pid, e.starve, e.crit, e.samp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (qa.size() > 0)
            compare("dut_a", '{int'(a_err), int'(a_code), int'(a_pid), int'(a_starve), int'(a_crit), int'(a_samp)},
                    qa.pop_front());
        if (qb.size() > 0)
            compare("dut_b", '{int'(b_err), int'(b_code), int'(b_pid), int'(b_starve), int'(b_crit), int'(b_samp)},
                    qb.pop_front());
    end

    task automatic apply(input bit rs, input bit v, input logic [3:0] nv, input bit xv, input bit cl);
        @(negedge clk);
        reset = rs; valid = v; n = nv; x = xv; clr = cl;
        for (int k = 0; k < 2; k++) begin
            if (rs) model_reset(k);
            else model_step(k, v, nv, xv, cl);
        end
        qa.push_back(exp_of(0));
        qb.push_back(exp_of(1));
    endtask

    task automatic smp(input logic [3:0] nv, input bit xv);
        apply(1'b0, 1'b1, nv, xv, 1'b0);
    endtask

    task automatic do_clr();
        apply(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    endtask

    task automatic check_now(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st[2];
        int r, j;
        logic [3:0] nv;
        bit xv;
        apply(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        settle();
        check_now("reset_err", int'(a_err), 0);
        check_now("reset_samp", int'(a_samp), 0);
        check_now("reset_starve", int'(a_starve), 0);

        smp(4'b0000, 1'b1); smp(4'b0001, 1'b1); smp(4'b0010, 1'b0); smp(4'b0011, 1'b0); smp(4'b0000, 1'b1);
        settle();
        check_now("walk_err", int'(a_err), 0);
        check_now("walk_crit", int'(a_crit), 1);
        check_now("walk_samp", int'(a_samp), 5);

        smp(4'b1010, 1'b0);
        settle();
        check_now("mutex_code", int'(a_code), 1);
        check_now("mutex_pid", int'(a_pid), 0);
        smp(4'b0001, 1'b1); smp(4'b0010, 1'b0);
        settle();
        check_now("mutex_frozen_samp", int'(a_samp), 5);
        do_clr(); smp(4'b0000, 1'b1);

        smp(4'b1000, 1'b0);
        settle();
        check_now("trans_code", int'(a_code), 3);
        check_now("trans_pid", int'(a_pid), 1);
        do_clr(); smp(4'b0000, 1'b1);
        settle();
        check_now("clr_err", int'(a_err), 0);

        smp(4'b0001, 1'b1); smp(4'b0010, 1'b1);
        settle();
        check_now("flag_code", int'(a_code), 2);
        do_clr(); smp(4'b0100, 1'b1);
        settle();
        check_now("init_code", int'(a_code), 4);
        check_now("init_pid", int'(a_pid), 1);

        do_clr(); smp(4'b0000, 1'b1);
        repeat (3) smp(4'b0100, 1'b1);
        settle();
        check_now("starve_early", int'(a_starve), 0);
        smp(4'b0100, 1'b1);
        settle();
        check_now("starve_set", int'(a_starve), 2);
        smp(4'b1000, 1'b0);
        settle();
        check_now("starve_clear", int'(a_starve), 0);
        smp(4'b1100, 1'b0); smp(4'b0000, 1'b1);

        smp(4'b0001, 1'b1); smp(4'b0110, 1'b0);
        settle();
        check_now("single_step_code", int'(a_code), 3);
        check_now("single_step_pid", int'(a_pid), 1);
        check_now("multi_step_ok", int'(b_err), 0);

        do_clr();
        repeat (20) smp(4'b0000, 1'b1);
        repeat (16) begin
            smp(4'b0001, 1'b1); smp(4'b0010, 1'b0); smp(4'b0011, 1'b0); smp(4'b0000, 1'b1);
        end
        settle();
        check_now("sat_crit", int'(b_crit), 15);

        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 2) apply(1'b1, 1'(r), 4'($urandom_range(0, 15)), 1'(r), 1'b0);
            else if (r < 6 || (m_mode[0] == 2 && r < 30)) do_clr();
            else if (r < 10) apply(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            else if (r < 18) smp(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else if (m_mode[0] == 0) smp(4'b0000, 1'b1);
            else begin
                st[0] = m_prev[0][0]; st[1] = m_prev[0][1];
                j = $urandom_range(0, 1);
                if ($urandom_range(0, 9) < 6) st[j] = (st[j] + 1) % 4;
                nv = 4'(st[1] * 4 + st[0]);
                xv = !(st[0] >= 2 || st[1] >= 2);
                smp(nv, xv);
            end
        end
        apply(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
